// File: rtl/vx_csr_timeit_unit.sv
// Timeit window CSR slave: holds the programmed PC window and enable, and measures
// elapsed cycles and committed instructions while any warp is inside the window.
module vx_csr_timeit_unit #(
    parameter int          NUM_WARPS   = 4,
    parameter int          NUM_THREADS = 4,
    parameter int          CMT_SIZE_W  = $clog2(6 * NUM_THREADS + 1),
    parameter logic [11:0] CSR_BASE    = 12'h7C0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmt_valid,
    input  logic [CMT_SIZE_W-1:0] cmt_commit_size,
    input  logic [NUM_WARPS-1:0]  cmt_timeit_active,
    input  logic                  csr_wr_en,
    input  logic [11:0]           csr_wr_addr,
    input  logic [31:0]           csr_wr_data,
    input  logic                  csr_rd_en,
    input  logic [11:0]           csr_rd_addr,
    output logic [31:0]           csr_rd_data,
    output logic                  csr_rd_valid,
    output logic [31:0]           timeit_start_addr,
    output logic [31:0]           timeit_end_addr,
    output logic                  timeit_enable
);

    localparam logic [11:0] ADDR_START  = CSR_BASE;
    localparam logic [11:0] ADDR_END    = CSR_BASE + 12'd1;
    localparam logic [11:0] ADDR_CTRL   = CSR_BASE + 12'd2;
    localparam logic [11:0] ADDR_CYCLES = CSR_BASE + 12'd3;
    localparam logic [11:0] ADDR_INSTRS = CSR_BASE + 12'd4;
    localparam logic [31:0] CNT_MAX     = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_TIMING = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] start_q, end_q;
    logic        enable_q, enable_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_valid_q;

    logic        wr_ctrl;
    logic        wr_clear;
    logic        wr_enable;
    logic        ctrl_override;
    logic        any_active;
    logic [31:0] cycle_inc;
    logic [32:0] instr_sum;
    logic [31:0] instr_add;

    assign wr_ctrl    = csr_wr_en && (csr_wr_addr == ADDR_CTRL);
    assign wr_clear   = wr_ctrl && csr_wr_data[1];
    assign wr_enable  = csr_wr_data[0];
    assign any_active = |cmt_timeit_active;

    // A CTRL write that changes the FSM (clear, disable, or re-arm) wins over counting.
    assign ctrl_override = wr_ctrl && (wr_clear || !wr_enable
                           || state_q == ST_IDLE || state_q == ST_DONE);

    assign cycle_inc = (cycle_cnt_q == CNT_MAX) ? CNT_MAX : cycle_cnt_q + 32'd1;
    assign instr_sum = {1'b0, instr_cnt_q} + {{(33 - CMT_SIZE_W){1'b0}}, cmt_commit_size};
    assign instr_add = instr_sum[32] ? CNT_MAX : instr_sum[31:0];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (wr_clear || (wr_ctrl && !wr_enable)) begin
            state_d = ST_IDLE;
        end else if (ctrl_override) begin
            state_d = ST_ARMED;
        end else begin
            case (state_q)
                ST_ARMED:  if (any_active)  state_d = ST_TIMING;
                ST_TIMING: if (!any_active) state_d = ST_DONE;
                default:   state_d = state_q;
            endcase
        end
    end

    // Output / datapath logic
    always_comb begin
        enable_d    = enable_q;
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (wr_clear) begin
            enable_d    = 1'b0;
            cycle_cnt_d = '0;
            instr_cnt_d = '0;
        end else if (wr_ctrl) begin
            enable_d = wr_enable;
            if (wr_enable && state_q == ST_DONE) begin
                cycle_cnt_d = '0;
                instr_cnt_d = '0;
            end
        end
        if (!ctrl_override && any_active) begin
            if (state_q == ST_ARMED) begin
                cycle_cnt_d = 32'd1;
                instr_cnt_d = cmt_valid ? {{(32 - CMT_SIZE_W){1'b0}}, cmt_commit_size} : '0;
            end else if (state_q == ST_TIMING) begin
                cycle_cnt_d = cycle_inc;
                if (cmt_valid) begin
                    instr_cnt_d = instr_add;
                end
            end
        end
    end

    // Read mux samples current register values, so a same-cycle write returns old data.
    always_comb begin
        rd_data_d = '0;
        if (csr_rd_en) begin
            case (csr_rd_addr)
                ADDR_START:  rd_data_d = start_q;
                ADDR_END:    rd_data_d = end_q;
                ADDR_CTRL:   rd_data_d = {28'd0, state_q, 1'b0, enable_q};
                ADDR_CYCLES: rd_data_d = cycle_cnt_q;
                ADDR_INSTRS: rd_data_d = instr_cnt_q;
                default:     rd_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q     <= '0;
            end_q       <= '0;
            enable_q    <= 1'b0;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            if (csr_wr_en && csr_wr_addr == ADDR_START) begin
                start_q <= csr_wr_data;
            end
            if (csr_wr_en && csr_wr_addr == ADDR_END) begin
                end_q <= csr_wr_data;
            end
            enable_q    <= enable_d;
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= csr_rd_en;
        end
    end

    assign csr_rd_data       = rd_data_q;
    assign csr_rd_valid      = rd_valid_q;
    assign timeit_start_addr = start_q;
    assign timeit_end_addr   = end_q;
    assign timeit_enable     = enable_q;

endmodule

// File: doc/vx_csr_timeit_unit.md
Name: VX_csr_timeit_unit

Overview:
- CSR-side slave of the commit-to-CSR timing channel. Holds the software-programmed timeit window and enable (start/end PC, enable).
- Consumes per-warp timeit_active and per-cycle commit_size from the commit stage. Measures elapsed cycles and committed instructions while any warp is inside the window.
- Exposes results through CSR read/write. Sits inside the CSR data unit, beside the instret/cycle counters.

Parameters:
- NUM_WARPS, 4, number of warps; width of the timeit_active vector.
- NUM_THREADS, 4, threads per warp; sizes commit_size.
- CMT_SIZE_W, $clog2(6*NUM_THREADS+1), commit_size width (FPU-enabled sizing; 5 at defaults).
- CSR_BASE, 12'h7C0, base CSR address of the unit.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cmt_valid  in  1  commit_size valid this cycle
- cmt_commit_size  in  CMT_SIZE_W  instructions committed this cycle
- cmt_timeit_active  in  NUM_WARPS  per-warp "inside window" flags from commit
- csr_wr_en  in  1  CSR write strobe
- csr_wr_addr  in  12  CSR write address
- csr_wr_data  in  32  CSR write data
- csr_rd_en  in  1  CSR read request
- csr_rd_addr  in  12  CSR read address
- csr_rd_data  out  32  read data, registered
- csr_rd_valid  out  1  read data valid
- timeit_start_addr  out  32  window start PC to commit
- timeit_end_addr  out  32  window end PC to commit
- timeit_enable  out  1  window measurement enabled

Behaviour:

Reset (asynchronous assert, synchronous deassert by clk):
- All outputs 0.
- State IDLE; cycle_cnt and instr_cnt 0.
- Reset mid-measurement discards everything.

CSR map (offsets from CSR_BASE):
- +0: START (RW)
- +1: END (RW)
- +2: CTRL. bit0 enable (RW); bit1 clear (W1, self-clearing, reads 0); bits[3:2] state (RO: 0 IDLE, 1 ARMED, 2 TIMING, 3 DONE).
- +3: CYCLES (RO)
- +4: INSTRS (RO)

CSR writes and reads:
- A write takes effect on the next clk edge, so the output is visible the following cycle.
- Writes to RO offsets are ignored. Unmapped addresses are ignored for writes and read as 0.
- Read latency is 1 cycle: csr_rd_valid pulses the cycle after csr_rd_en, with csr_rd_data registered.
- A read and a write to the same address in the same cycle return the old value.

FSM:
- IDLE -> ARMED when CTRL.enable is written 1.
- ARMED -> TIMING on the first cycle |cmt_timeit_active=1. In that cycle, counting starts: cycle_cnt=1, and instr_cnt adds commit_size if cmt_valid.
- TIMING: every cycle, cycle_cnt+=1. While cmt_valid, instr_cnt+=cmt_commit_size (zero-extended to 32 bits).
- TIMING -> DONE on the first cycle |cmt_timeit_active=0. That cycle is not counted. Counters freeze.
- DONE holds until clear or until enable is rewritten.
- Writing enable=0 in any state -> IDLE and timeit_enable=0. Counters are kept, not zeroed.
- Writing enable=1 while in DONE -> ARMED with counters zeroed.

Clear and saturation:
- Clear -> IDLE, counters 0, enable bit 0.
- Clear has priority over an enable write in the same data word and over counting in the same cycle.
- Both counters saturate at 32'hFFFFFFFF; no wrap.
- instr_cnt saturation: if the sum overflows, the result is FFFFFFFF.

Enable output:
- timeit_enable = CTRL.enable bit, registered.
- cmt_timeit_active is sampled only in ARMED and TIMING; it is ignored otherwise.
- cmt_commit_size is ignored when cmt_valid=0.

Test Plan:
1. Reset then read +0..+4 -> all return 0. csr_rd_valid is high exactly 1 cycle after each rd_en. Outputs are 0.
2. Write START=0x80000100, END=0x80000200, CTRL=1 -> next cycle timeit_start_addr=0x80000100, timeit_end_addr=0x80000200, timeit_enable=1. CTRL reads state=1 (0x5).
3. Armed; active=4'b0010 for 10 cycles with cmt_valid=1, size=4 each cycle, then active=0 -> CYCLES=10, INSTRS=40, state=DONE (CTRL reads 0xD).
4. Armed; active toggles between warps 0 and 3 with no all-zero gap for 7 cycles, with cmt_valid=0 on 3 of the cycles and size=24 on the others -> CYCLES=7, INSTRS=96.
5. Preload instr_cnt near max (force 0xFFFFFFF0) during TIMING with size=24 -> INSTRS=0xFFFFFFFF and stays there.
6. Assert reset mid-TIMING (async, between edges) -> outputs 0 immediately, state IDLE, counters 0. A clear write during TIMING -> counters 0 and timeit_enable=0 the next cycle.
